// File: rtl/squash_game_ctrl.sv
// Game-flow sequencer for solo squash: serve/play/miss flow, BCD score, lives, tones.
// Define HISCORE_EN to build the BCD high-score register.
module squash_game_ctrl #(
  parameter int LIVES        = 3,
  parameter int SERVE_FRAMES = 30,
  parameter int MISS_FRAMES  = 45,
  parameter int HIT_FRAMES   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic       pause_btn,
  input  logic       hit,
  input  logic       miss,
  output logic       run,
  output logic       serve,
  output logic [2:0] state,
  output logic [7:0] score,
  output logic [1:0] lives,
  output logic [7:0] hiscore,
  output logic       tone_en,
  output logic       tone_sel
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SERVE  = 3'd1,
    S_PLAY   = 3'd2,
    S_PAUSED = 3'd3,
    S_MISS   = 3'd4,
    S_OVER   = 3'd5
  } state_t;

  localparam logic [5:0] SERVE_LAST = 6'(SERVE_FRAMES - 1);
  localparam logic [5:0] MISS_LAST  = 6'(MISS_FRAMES - 1);
  localparam logic [5:0] HIT_LAST   = 6'(HIT_FRAMES - 1);
  localparam logic [1:0] LIVES_INIT = 2'(LIVES);

  state_t     st_q, st_d;
  logic [5:0] cnt_q, cnt_d;
  logic [5:0] tcnt_q, tcnt_d;
  logic [7:0] score_q, score_d;
  logic [1:0] lives_q, lives_d;
  logic       ten_q, ten_d;
  logic       tsel_q, tsel_d;
  logic       run_q;
  logic       start_q, pause_q;
  logic       start_rise, pause_rise;
  logic       serve_d;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v == 8'h99)
      return v;
    else if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  assign start_rise = start_btn & ~start_q;
  assign pause_rise = pause_btn & ~pause_q;

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    tcnt_d  = tcnt_q;
    score_d = score_q;
    lives_d = lives_q;
    ten_d   = ten_q;
    tsel_d  = tsel_q;
    serve_d = 1'b0;
    if (start_rise) begin
      st_d    = S_SERVE;
      score_d = 8'h00;
      lives_d = LIVES_INIT;
      cnt_d   = 6'd0;
      tcnt_d  = 6'd0;
      ten_d   = 1'b0;
      tsel_d  = 1'b0;
    end else begin
      unique case (st_q)
        S_SERVE: begin
          if (frame_tick) begin
            if (cnt_q == SERVE_LAST) begin
              serve_d = 1'b1;
              st_d    = S_PLAY;
              cnt_d   = 6'd0;
            end else begin
              cnt_d = cnt_q + 6'd1;
            end
          end
        end
        S_PLAY: begin
          if (miss) begin
            st_d    = S_MISS;
            lives_d = lives_q - 2'd1;
            cnt_d   = 6'd0;
            tcnt_d  = 6'd0;
            ten_d   = 1'b1;
            tsel_d  = 1'b1;
          end else begin
            if (hit) begin
              score_d = bcd_inc(score_q);
              ten_d   = 1'b1;
              tsel_d  = 1'b0;
              tcnt_d  = 6'd0;
            end else if (frame_tick && ten_q && !tsel_q) begin
              if (tcnt_q == HIT_LAST) begin
                ten_d  = 1'b0;
                tcnt_d = 6'd0;
              end else begin
                tcnt_d = tcnt_q + 6'd1;
              end
            end
            if (pause_rise) st_d = S_PAUSED;
          end
        end
        S_PAUSED: begin
          if (pause_rise) st_d = S_PLAY;
        end
        S_MISS: begin
          if (frame_tick) begin
            if (cnt_q == MISS_LAST) begin
              st_d   = (lives_q == 2'd0) ? S_OVER : S_SERVE;
              cnt_d  = 6'd0;
              ten_d  = 1'b0;
              tsel_d = 1'b0;
            end else begin
              cnt_d = cnt_q + 6'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= S_IDLE;
      cnt_q   <= 6'd0;
      tcnt_q  <= 6'd0;
      score_q <= 8'h00;
      lives_q <= 2'd0;
      ten_q   <= 1'b0;
      tsel_q  <= 1'b0;
      run_q   <= 1'b0;
      start_q <= 1'b1;
      pause_q <= 1'b1;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      tcnt_q  <= tcnt_d;
      score_q <= score_d;
      lives_q <= lives_d;
      ten_q   <= ten_d;
      tsel_q  <= tsel_d;
      run_q   <= (st_d == S_PLAY);
      start_q <= start_btn;
      pause_q <= pause_btn;
    end
  end

`ifdef HISCORE_EN
  logic [7:0] hiscore_q;

  // Packed BCD orders the same as binary, so a plain compare works.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      hiscore_q <= 8'h00;
    else if (st_d == S_OVER && st_q != S_OVER && score_q > hiscore_q)
      hiscore_q <= score_q;
  end

  assign hiscore = hiscore_q;
`else
  assign hiscore = 8'h00;
`endif

  assign run      = run_q;
  assign serve    = serve_d;
  assign state    = st_q;
  assign score    = score_q;
  assign lives    = lives_q;
  assign tone_en  = ten_q;
  assign tone_sel = tsel_q;

endmodule

// File: tb/tb_squash_game_ctrl.sv
// Directed bench for squash_game_ctrl.
// Expected high scores follow HISCORE_EN.
module tb_squash_game_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_tick, start_btn, pause_btn;
  logic       hit, miss;
  logic       run, serve, tone_en, tone_sel;
  logic [2:0] state;
  logic [7:0] score, hiscore;
  logic [1:0] lives;

  int total = 0;
  int bad = 0;
  int serve_cnt = 0;

`ifdef HISCORE_EN
  localparam logic [7:0] HS = 8'h07;
`else
  localparam logic [7:0] HS = 8'h00;
`endif

  squash_game_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .frame_tick(frame_tick),
    .start_btn(start_btn),
    .pause_btn(pause_btn),
    .hit(hit), .miss(miss),
    .run(run), .serve(serve),
    .state(state), .score(score),
    .lives(lives), .hiscore(hiscore),
    .tone_en(tone_en), .tone_sel(tone_sel)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (serve === 1'b1) serve_cnt++;

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic ft, st, pb, h, m);
    frame_tick = ft;
    start_btn  = st;
    pause_btn  = pb;
    hit        = h;
    miss       = m;
    @(posedge clk);
    #2;
    frame_tick = 1'b0;
    start_btn  = 1'b0;
    pause_btn  = 1'b0;
    hit        = 1'b0;
    miss       = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic hits(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic lose_all;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      ticks(45);
      if (i < 2) ticks(30);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    frame_tick = 1'b0; start_btn = 1'b0;
    pause_btn = 1'b0; hit = 1'b0; miss = 1'b0;
    #1;
    chk("rst_state", 8'(state), 8'd0);
    chk("rst_score", score, 8'h00);
    chk("rst_lives", 8'(lives), 8'd0);
    chk("rst_hiscore", hiscore, 8'h00);
    chk("rst_run", 8'(run), 8'd0);
    chk("rst_serve", 8'(serve), 8'd0);
    chk("rst_tone", 8'({tone_en, tone_sel}), 8'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    chk("start_state", 8'(state), 8'd1);
    chk("start_lives", 8'(lives), 8'd3);
    chk("start_run", 8'(run), 8'd0);

    serve_cnt = 0;
    ticks(29);
    chk("serve_wait_state", 8'(state), 8'd1);
    chk("serve_wait_pulse", 8'(serve_cnt), 8'd0);
    ticks(1);
    chk("serve_pulse", 8'(serve_cnt), 8'd1);
    chk("play_state", 8'(state), 8'd2);
    chk("play_run", 8'(run), 8'd1);
    chk("play_lives", 8'(lives), 8'd3);
    chk("play_score", score, 8'h00);

    hits(12);
    chk("score12", score, 8'h12);
    chk("hit_tone", 8'({tone_en, tone_sel}), 8'b10);
    ticks(3);
    chk("hit_tone_3", 8'(tone_en), 8'd1);
    ticks(1);
    chk("hit_tone_off", 8'(tone_en), 8'd0);

    cyc(0, 0, 1, 0, 0);
    chk("pause_state", 8'(state), 8'd3);
    chk("pause_run", 8'(run), 8'd0);
    cyc(0, 0, 0, 1, 0);
    chk("pause_hit", score, 8'h12);
    cyc(0, 0, 0, 0, 1);
    chk("pause_miss", 8'(state), 8'd3);
    cyc(0, 0, 1, 0, 0);
    chk("resume_state", 8'(state), 8'd2);
    chk("resume_run", 8'(run), 8'd1);

    hits(88);
    chk("score99", score, 8'h99);
    hits(1);
    chk("score_sat", score, 8'h99);

    cyc(0, 0, 0, 1, 1);
    chk("hm_score", score, 8'h99);
    chk("hm_state", 8'(state), 8'd4);
    chk("hm_lives", 8'(lives), 8'd2);
    chk("hm_tone", 8'({tone_en, tone_sel}), 8'b11);
    chk("hm_run", 8'(run), 8'd0);
    ticks(44);
    chk("miss_44_state", 8'(state), 8'd4);
    chk("miss_44_sel", 8'(tone_sel), 8'd1);
    ticks(1);
    chk("miss_end_state", 8'(state), 8'd1);
    chk("miss_end_tone", 8'(tone_en), 8'd0);

    ticks(30);
    chk("replay_state", 8'(state), 8'd2);
    cyc(0, 0, 0, 0, 1);
    chk("miss2_lives", 8'(lives), 8'd1);
    ticks(10);
    cyc(0, 1, 0, 0, 0);
    chk("restart_state", 8'(state), 8'd1);
    chk("restart_lives", 8'(lives), 8'd3);
    chk("restart_score", score, 8'h00);
    chk("restart_tone", 8'(tone_en), 8'd0);

    ticks(30);
    hits(7);
    chk("g2_score", score, 8'h07);
    lose_all;
    chk("over_state", 8'(state), 8'd5);
    chk("over_lives", 8'(lives), 8'd0);
    chk("over_run", 8'(run), 8'd0);
    chk("over_hiscore", hiscore, HS);
    cyc(1, 0, 0, 1, 0);
    chk("over_hold_score", score, 8'h07);
    chk("over_hold_state", 8'(state), 8'd5);

    cyc(0, 1, 0, 0, 0);
    chk("g3_state", 8'(state), 8'd1);
    chk("g3_score", score, 8'h00);
    ticks(30);
    hits(5);
    lose_all;
    chk("g3_over", 8'(state), 8'd5);
    chk("g3_score_end", score, 8'h05);
    chk("g3_hiscore", hiscore, HS);

    cyc(0, 1, 0, 0, 0);
    #3 rst_n = 1'b0;
    #1;
    chk("async_state", 8'(state), 8'd0);
    chk("async_lives", 8'(lives), 8'd0);
    chk("async_hiscore", hiscore, 8'h00);
    start_btn = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("held_start", 8'(state), 8'd0);
    start_btn = 1'b0;
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    chk("post_held_start", 8'(state), 8'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
